// File: rtl/pulse_distance_tx.sv
// Pulse-distance serial transmitter: sync mark, BIT_DEPTH low/high pulse pairs, stop pulse.
// Optional carrier modulation of high phases under `PULSE_DISTANCE_TX_CARRIER_EN.
module pulse_distance_tx #(
  parameter int BIT_DEPTH    = 16,
  parameter int SYNC_LO      = 400,
  parameter int SYNC_HI      = 600,
  parameter int BIT_LO       = 200,
  parameter int ZERO_HI      = 200,
  parameter int ONE_HI       = 600,
  parameter int MSB_FIRST    = 1,
  parameter int CARRIER_HALF = 13
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic [BIT_DEPTH-1:0] data_in,
  input  logic                 data_valid_in,
  output logic                 data_ready_out,
  output logic                 busy_out,
  output logic                 done_out,
  output logic                 out
);

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int MAX_LEN = max2(max2(max2(SYNC_LO, SYNC_HI), max2(BIT_LO, ZERO_HI)), ONE_HI);
  localparam int CNT_W   = $clog2(MAX_LEN) + 1;
  localparam int BIT_W   = $clog2(BIT_DEPTH) + 1;

  generate
    if (BIT_DEPTH < 1 || BIT_DEPTH > 32) begin : g_bad_depth
      $error("pulse_distance_tx: BIT_DEPTH must be 1..32");
    end
    if (SYNC_LO < 1 || SYNC_HI < 1 || BIT_LO < 1 || ZERO_HI < 1 || ONE_HI < 1) begin : g_bad_len
      $error("pulse_distance_tx: phase lengths must be non-zero");
    end
    if (ZERO_HI == ONE_HI) begin : g_bad_enc
      $error("pulse_distance_tx: ZERO_HI and ONE_HI must differ");
    end
    if (CARRIER_HALF < 1) begin : g_bad_car
      $error("pulse_distance_tx: CARRIER_HALF must be non-zero");
    end
  endgenerate

  typedef enum logic [2:0] {IDLE, SYNC_L, SYNC_H, BIT_L, BIT_H, STOP} state_t;

  state_t               state_reg, state_next;
  logic [CNT_W-1:0]     cnt_reg, cnt_next;
  logic [BIT_W-1:0]     bit_cnt_reg, bit_cnt_next;
  logic [BIT_DEPTH-1:0] shift_reg, shift_next;
  logic [BIT_DEPTH-1:0] pend_reg, pend_next;
  logic                 pend_full_reg, pend_full_next;
  logic                 ready_reg, ready_next;
  logic                 busy_reg, busy_next;
  logic                 done_reg, done_next;
  logic                 out_reg, out_next;

  logic                 accept;
  logic                 cur_bit;
  logic [CNT_W-1:0]     phase_len;
  logic                 phase_last;
  logic                 high_next;

  assign accept  = data_valid_in && ready_reg;
  assign cur_bit = (MSB_FIRST != 0) ? shift_reg[BIT_DEPTH-1] : shift_reg[0];

  always_comb begin
    phase_len = CNT_W'(BIT_LO);
    case (state_reg)
      SYNC_L:  phase_len = CNT_W'(SYNC_LO);
      SYNC_H:  phase_len = CNT_W'(SYNC_HI);
      BIT_H:   phase_len = cur_bit ? CNT_W'(ONE_HI) : CNT_W'(ZERO_HI);
      default: phase_len = CNT_W'(BIT_LO);
    endcase
  end

  assign phase_last = (cnt_reg == phase_len - CNT_W'(1));

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      bit_cnt_reg   <= '0;
      shift_reg     <= '0;
      pend_reg      <= '0;
      pend_full_reg <= 1'b0;
      ready_reg     <= 1'b1;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      out_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      bit_cnt_reg   <= bit_cnt_next;
      shift_reg     <= shift_next;
      pend_reg      <= pend_next;
      pend_full_reg <= pend_full_next;
      ready_reg     <= ready_next;
      busy_reg      <= busy_next;
      done_reg      <= done_next;
      out_reg       <= out_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg + CNT_W'(1);
    bit_cnt_next   = bit_cnt_reg;
    shift_next     = shift_reg;
    pend_next      = pend_reg;
    pend_full_next = pend_full_reg;
    done_next      = 1'b0;

    case (state_reg)
      IDLE: begin
        cnt_next = '0;
        if (accept) begin
          shift_next = data_in;
          state_next = SYNC_L;
        end
      end
      SYNC_L: begin
        if (phase_last) begin
          state_next = SYNC_H;
          cnt_next   = '0;
        end
      end
      SYNC_H: begin
        if (phase_last) begin
          state_next   = BIT_L;
          cnt_next     = '0;
          bit_cnt_next = '0;
        end
      end
      BIT_L: begin
        if (phase_last) begin
          state_next = BIT_H;
          cnt_next   = '0;
        end
      end
      BIT_H: begin
        if (phase_last) begin
          cnt_next     = '0;
          shift_next   = (MSB_FIRST != 0) ? (shift_reg << 1) : (shift_reg >> 1);
          bit_cnt_next = bit_cnt_reg + BIT_W'(1);
          state_next   = (bit_cnt_reg == BIT_W'(BIT_DEPTH - 1)) ? STOP : BIT_L;
        end
      end
      STOP: begin
        if (phase_last) begin
          cnt_next  = '0;
          done_next = 1'b1;
          if (pend_full_reg) begin
            shift_next     = pend_reg;
            pend_full_next = 1'b0;
            state_next     = SYNC_L;
          end else if (accept) begin
            // A word arriving on the final stop cycle chains straight into the next frame.
            shift_next = data_in;
            state_next = SYNC_L;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase

    if (accept && state_reg != IDLE && !(state_reg == STOP && phase_last)) begin
      pend_next      = data_in;
      pend_full_next = 1'b1;
    end
  end

  assign busy_next  = (state_next != IDLE);
  assign ready_next = !pend_full_next;
  assign high_next  = (state_next == SYNC_H) || (state_next == BIT_H);

`ifdef PULSE_DISTANCE_TX_CARRIER_EN
  localparam int CAR_W = $clog2(CARRIER_HALF) + 1;

  logic [CAR_W-1:0] car_cnt_reg, car_cnt_next;
  logic             high_enter;

  // Every high phase is entered from a different state, so a state change marks its start.
  assign high_enter = high_next && (state_next != state_reg);

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      car_cnt_reg <= '0;
    end else begin
      car_cnt_reg <= car_cnt_next;
    end
  end

  always_comb begin
    car_cnt_next = '0;
    out_next     = 1'b0;
    if (high_next) begin
      if (high_enter) begin
        out_next = 1'b1;
      end else if (car_cnt_reg == CAR_W'(CARRIER_HALF - 1)) begin
        out_next = ~out_reg;
      end else begin
        out_next     = out_reg;
        car_cnt_next = car_cnt_reg + CAR_W'(1);
      end
    end
  end
`else
  assign out_next = high_next;
`endif

  assign data_ready_out = ready_reg;
  assign busy_out       = busy_reg;
  assign done_out       = done_reg;
  assign out            = out_reg;

endmodule
